// File: rtl/regfile_sb_if.sv
// Decode/writeback-facing bundle of the register file: two read ports, one write port, issue and bulk clear.
// The master drives addresses, write data and control; the slave returns data, ready flags and busy.
interface regfile_sb_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] A1;
  logic [ADDR_WIDTH-1:0] A2;
  logic [DATA_WIDTH-1:0] RD1;
  logic [DATA_WIDTH-1:0] RD2;
  logic                  RDY1;
  logic                  RDY2;
  logic [ADDR_WIDTH-1:0] A3;
  logic [DATA_WIDTH-1:0] WD3;
  logic                  WE3;
  logic                  ISSUE_EN;
  logic [ADDR_WIDTH-1:0] ISSUE_ADDR;
  logic                  CLR_START;
  logic                  CLR_BUSY;

  modport master (
    output A1, A2, A3, WD3, WE3, ISSUE_EN, ISSUE_ADDR, CLR_START,
    input  RD1, RD2, RDY1, RDY2, CLR_BUSY
  );

  modport slave (
    input  A1, A2, A3, WD3, WE3, ISSUE_EN, ISSUE_ADDR, CLR_START,
    output RD1, RD2, RDY1, RDY2, CLR_BUSY
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with pending-write scoreboard and bulk clear; reads are zero-latency, writes land at the next edge.
// No backpressure: during a clear, writes, issues and clear requests are dropped and both ready flags are held low.
module regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic         CLK,
  input  logic         reset,
  regfile_sb_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  busy_q;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      pend_q;
  logic [DEPTH-1:0]      pend_d;

  logic idle;
  logic wr_ok;
  logic iss_ok;
  logic zero1;
  logic zero2;
  logic byp1;
  logic byp2;

  assign idle   = (state_q == IDLE);
  assign wr_ok  = idle && bus.WE3 && !((ZERO_REG != 0) && (bus.A3 == '0));
  assign iss_ok = idle && bus.ISSUE_EN && !((ZERO_REG != 0) && (bus.ISSUE_ADDR == '0));

  // wr_ok already excludes the clear, so forwarding is off while clearing.
  assign zero1 = (ZERO_REG != 0) && (bus.A1 == '0);
  assign zero2 = (ZERO_REG != 0) && (bus.A2 == '0);
  assign byp1  = (BYPASS != 0) && wr_ok && (bus.A3 == bus.A1);
  assign byp2  = (BYPASS != 0) && wr_ok && (bus.A3 == bus.A2);

  assign bus.RD1  = zero1 ? '0 : (byp1 ? bus.WD3 : regs_q[bus.A1]);
  assign bus.RD2  = zero2 ? '0 : (byp2 ? bus.WD3 : regs_q[bus.A2]);
  assign bus.RDY1 = idle && (zero1 || byp1 || !pend_q[bus.A1]);
  assign bus.RDY2 = idle && (zero2 || byp2 || !pend_q[bus.A2]);
  assign bus.CLR_BUSY = busy_q;

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (!idle) begin
      regs_d[cnt_q] = '0;
      pend_d[cnt_q] = 1'b0;
    end else begin
      if (wr_ok) begin
        regs_d[bus.A3] = bus.WD3;
        pend_d[bus.A3] = 1'b0;
      end
      // Issue is applied last so it wins over a same-address write.
      if (iss_ok) begin
        pend_d[bus.ISSUE_ADDR] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.CLR_START) begin
            state_q <= CLEARING;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEARING: begin
          cnt_q <= cnt_q + ADDR_WIDTH'(1);
          if (&cnt_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Randomised bench for regfile_sb against an array-based model, plus directed scenarios with literal expectations.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_sb_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  regfile_sb #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32),
    .ZERO_REG(1),
    .BYPASS(1)
  ) dut (
    .CLK  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          n_chk;
  int          n_fail;
  int          busy_cnt;
  int          clear_left;
  logic [31:0] mreg [32];
  bit          mpend [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (clear_left == 0 && bus.WE3 && bus.A3 == a) return bus.WD3;
    return mreg[a];
  endfunction

  function automatic logic [31:0] exp_rdy(input logic [4:0] a);
    if (clear_left > 0) return 32'd0;
    if (a == 5'd0) return 32'd1;
    if (bus.WE3 && bus.A3 == a) return 32'd1;
    return mpend[a] ? 32'd0 : 32'd1;
  endfunction

  task automatic model_update();
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        mreg[i]  = 32'd0;
        mpend[i] = 1'b0;
      end
      clear_left = 0;
    end else if (clear_left > 0) begin
      mreg[32 - clear_left]  = 32'd0;
      mpend[32 - clear_left] = 1'b0;
      clear_left--;
    end else begin
      if (bus.WE3 && bus.A3 != 5'd0) begin
        mreg[bus.A3]  = bus.WD3;
        mpend[bus.A3] = 1'b0;
      end
      if (bus.ISSUE_EN && bus.ISSUE_ADDR != 5'd0) mpend[bus.ISSUE_ADDR] = 1'b1;
      if (bus.CLR_START) clear_left = 32;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("RD1", bus.RD1, exp_rd(bus.A1));
    chk("RD2", bus.RD2, exp_rd(bus.A2));
    chk("RDY1", {31'd0, bus.RDY1}, exp_rdy(bus.A1));
    chk("RDY2", {31'd0, bus.RDY2}, exp_rdy(bus.A2));
    chk("CLR_BUSY", {31'd0, bus.CLR_BUSY}, (clear_left > 0) ? 32'd1 : 32'd0);
    if (bus.CLR_BUSY) busy_cnt++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic quiet();
    reset          = 1'b1;
    bus.A1         = '0;
    bus.A2         = '0;
    bus.A3         = '0;
    bus.WD3        = '0;
    bus.WE3        = 1'b0;
    bus.ISSUE_EN   = 1'b0;
    bus.ISSUE_ADDR = '0;
    bus.CLR_START  = 1'b0;
  endtask

  task automatic rnd(input bit allow_clr);
    bus.A1         = 5'($urandom_range(0, 31));
    bus.A2         = 5'($urandom_range(0, 31));
    bus.A3         = 5'($urandom_range(0, 31));
    bus.WD3        = $urandom;
    bus.WE3        = 1'($urandom_range(0, 1));
    bus.ISSUE_EN   = 1'($urandom_range(0, 1));
    bus.ISSUE_ADDR = 5'($urandom_range(0, 31));
    bus.CLR_START  = allow_clr && ($urandom_range(0, 39) == 0);
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      bus.A1 = 5'(i);
      bus.A2 = 5'(31 - i);
      #1;
      chk({tag, "_rd1"}, bus.RD1, 32'd0);
      chk({tag, "_rd2"}, bus.RD2, 32'd0);
      chk({tag, "_rdy1"}, {31'd0, bus.RDY1}, 32'd1);
      chk({tag, "_busy"}, {31'd0, bus.CLR_BUSY}, 32'd0);
      cycle();
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; busy_cnt = 0; clear_left = 0;
    quiet();
    reset = 1'b0;
    @(posedge clk);
    model_update();
    #1;
    reset = 1'b1;

    // Reset after random traffic
    for (int k = 0; k < 20; k++) begin
      rnd(1'b0);
      cycle();
    end
    quiet();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    sweep_zero("reset");

    // Write with bypass, then stored value
    quiet();
    bus.WE3 = 1'b1; bus.A3 = 5'd5; bus.WD3 = 32'hDEADBEEF; bus.A1 = 5'd5;
    #1; chk("byp_rd1", bus.RD1, 32'hDEADBEEF);
    cycle();
    bus.WE3 = 1'b0;
    #1; chk("stored_rd1", bus.RD1, 32'hDEADBEEF);
    cycle();

    // Register 0 ignores writes and issues
    for (int k = 0; k < 3; k++) begin
      quiet();
      bus.WE3 = 1'b1; bus.A3 = 5'd0; bus.WD3 = 32'hFFFFFFFF;
      bus.ISSUE_EN = 1'b1; bus.ISSUE_ADDR = 5'd0; bus.A1 = 5'd0;
      #1;
      chk("r0_rd1", bus.RD1, 32'd0);
      chk("r0_rdy1", {31'd0, bus.RDY1}, 32'd1);
      cycle();
    end

    // Scoreboard
    quiet();
    bus.ISSUE_EN = 1'b1; bus.ISSUE_ADDR = 5'd7;
    cycle();
    quiet();
    bus.A2 = 5'd7;
    for (int k = 0; k < 3; k++) cycle();
    #1; chk("sb_pending", {31'd0, bus.RDY2}, 32'd0);
    bus.WE3 = 1'b1; bus.A3 = 5'd7; bus.WD3 = 32'h1234;
    #1; chk("sb_byp_rdy", {31'd0, bus.RDY2}, 32'd1);
    cycle();
    bus.WE3 = 1'b0;
    #1; chk("sb_after_rdy", {31'd0, bus.RDY2}, 32'd1);
    cycle();
    bus.WE3 = 1'b1; bus.WD3 = 32'h5678; bus.ISSUE_EN = 1'b1; bus.ISSUE_ADDR = 5'd7;
    cycle();
    quiet();
    bus.A2 = 5'd7;
    #1;
    chk("sb_iss_wins", {31'd0, bus.RDY2}, 32'd0);
    chk("sb_iss_data", bus.RD2, 32'h5678);
    cycle();

    // Randomised traffic with occasional clears and resets
    for (int k = 0; k < 400; k++) begin
      rnd(1'b1);
      reset = ($urandom_range(0, 99) != 0);
      cycle();
    end
    quiet();
    for (int k = 0; k < 34; k++) cycle();

    // Bulk clear with writes attempted throughout
    for (int i = 0; i < 32; i++) begin
      quiet();
      bus.WE3 = 1'b1; bus.A3 = 5'(i); bus.WD3 = 32'hA5000000 | 32'(i);
      cycle();
    end
    quiet();
    bus.CLR_START = 1'b1;
    cycle();
    busy_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      rnd(1'b1);
      #1;
      chk("clr_rdy1", {31'd0, bus.RDY1}, 32'd0);
      chk("clr_rdy2", {31'd0, bus.RDY2}, 32'd0);
      cycle();
    end
    quiet();
    #1; chk("clr_done", {31'd0, bus.CLR_BUSY}, 32'd0);
    cycle();
    chk("clr_len", 32'(busy_cnt), 32'd32);
    sweep_zero("clr");

    // Reset in the middle of a clear
    for (int i = 1; i < 32; i += 3) begin
      quiet();
      bus.WE3 = 1'b1; bus.A3 = 5'(i); bus.WD3 = $urandom | 32'd1;
      cycle();
    end
    quiet();
    bus.CLR_START = 1'b1;
    cycle();
    quiet();
    for (int k = 0; k < 10; k++) cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    #1; chk("mid_busy", {31'd0, bus.CLR_BUSY}, 32'd0);
    sweep_zero("mid");
    quiet();
    bus.WE3 = 1'b1; bus.A3 = 5'd9; bus.WD3 = 32'hCAFE;
    cycle();
    quiet();
    bus.A1 = 5'd9;
    #1; chk("mid_write", bus.RD1, 32'hCAFE);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the core's integer register file. Two combinational read ports and one synchronous write port, with:
- register 0 optionally hardwired to zero;
- optional write-to-read bypass;
- a per-register pending-write scoreboard driving operand-ready flags for the decode stage;
- a sequential bulk-clear engine for soft reinitialisation without asserting reset.

Sits between decode (reads, issue) and writeback (write) in the single-cycle/pipelined datapath.

Parameters:
- ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32, register width in bits.
- ZERO_REG, 1, 1 = entry 0 reads as 0, ignores writes and issues, and is always ready.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports and ready flags.

Ports:
- CLK, input, 1, clock, rising edge.
- reset, input, 1, synchronous active-low reset.
- A1, input, ADDR_WIDTH, read address port 1.
- A2, input, ADDR_WIDTH, read address port 2.
- RD1, output, DATA_WIDTH, read data port 1.
- RD2, output, DATA_WIDTH, read data port 2.
- RDY1, output, 1, operand at A1 has no outstanding write.
- RDY2, output, 1, operand at A2 has no outstanding write.
- A3, input, ADDR_WIDTH, write address.
- WD3, input, DATA_WIDTH, write data.
- WE3, input, 1, write enable.
- ISSUE_EN, input, 1, mark ISSUE_ADDR as pending.
- ISSUE_ADDR, input, ADDR_WIDTH, destination register of the issuing instruction.
- CLR_START, input, 1, start bulk clear (single-cycle pulse).
- CLR_BUSY, output, 1, bulk clear in progress.

Behaviour:

Reset:
- One clock; reset is synchronous and active-low: sampled only at the CLK rising edge with reset==0.
- On reset, all DEPTH entries become 0, all pending bits become 0, the FSM goes to IDLE, the clear counter becomes 0 and CLR_BUSY = 0.
- Reset overrides every other input, including mid-clear.

Write (FSM in IDLE only):
- At posedge with WE3=1: REG[A3] <= WD3 and pending[A3] <= 0.
- Suppressed when ZERO_REG=1 and A3=0.

Issue (FSM in IDLE only):
- At posedge with ISSUE_EN=1: pending[ISSUE_ADDR] <= 1.
- Suppressed when ZERO_REG=1 and ISSUE_ADDR=0.
- Issue and write to the same address in the same cycle: the data is written and the pending bit ends at 1 (issue wins).
- Issue and write to different addresses: both take effect.

Read (combinational, zero latency), priority order for each port n:
1. ZERO_REG=1 and An=0 -> RDn = 0.
2. BYPASS=1, IDLE, WE3=1 and A3=An -> RDn = WD3.
3. Otherwise RDn = REG[An].

Ready flags:
- In IDLE, RDYn = ~pending[An].
- Also RDYn = 1 when BYPASS=1 and a write to An is present this cycle.
- Also RDYn = 1 when ZERO_REG=1 and An=0.
- In CLEARING, RDY1 = RDY2 = 0.

Clear FSM, two states:
- IDLE -> CLEARING on CLR_START=1.
- In CLEARING, at each posedge: REG[cnt] <= 0, pending[cnt] <= 0, cnt <= cnt+1.
- cnt = DEPTH-1 -> IDLE; cnt wraps to 0.
- The clear occupies exactly DEPTH cycles. CLR_BUSY = 1 exactly during those DEPTH cycles.
- In CLEARING, WE3, ISSUE_EN and CLR_START are ignored (dropped, not queued) and bypass is disabled; reads return stored values, which may be partially cleared.
- CLR_START with WE3 in the same IDLE cycle: the write commits and the clear starts next cycle, so the entry is later zeroed.

Widths:
- No arithmetic on data.
- cnt is ADDR_WIDTH bits.

Test Plan:
1. Reset: hold reset=0 for 1 cycle after random writes, then read all addresses -> every RD = 0, RDY = 1, CLR_BUSY = 0.
2. Write and bypass: WE3=1, A3=5, WD3=0xDEADBEEF, A1=5 in the same cycle -> RD1 = 0xDEADBEEF before the edge (BYPASS=1). Next cycle with WE3=0 -> RD1 still 0xDEADBEEF.
3. Register 0: WE3=1, A3=0, WD3=0xFFFFFFFF and ISSUE_EN=1, ISSUE_ADDR=0 -> RD1 with A1=0 = 0 and RDY1 = 1 on every cycle.
4. Scoreboard: issue addr 7, then wait 3 cycles -> RDY2 = 0 with A2=7. Write 7 with 0x1234 -> RDY2 = 1 in the write cycle via bypass and remains 1 after. Simultaneous issue and write of 7 -> RDY2 = 0 next cycle, RD2 = written data.
5. Bulk clear: fill all 32 entries, pulse CLR_START -> CLR_BUSY high for exactly 32 cycles, RDY1/RDY2 = 0 throughout, WE3 during the clear is dropped, all entries = 0 after.
6. Reset mid-clear: assert reset=0 at clear cycle 10 -> next cycle CLR_BUSY = 0, IDLE, all entries 0, and a subsequent write works normally.
